row_clear_engine: RTL
=====================

ROW_CLEAR_ENGINE -- requirements
Module: row_clear_engine

Interface
REQ-001 Parameter COLS, default 10, board width in cells; one bit per cell.
REQ-002 Parameter ROWS, default 32, board memory depth in rows.
REQ-003 Parameter TOP_ROW, default 3, highest (smallest-address) playfield row; SHALL be >= 1.
REQ-004 Parameter BOTTOM_ROW, default 22, lowest (largest-address) playfield row; TOP_ROW < BOTTOM_ROW < ROWS.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 start  input  1  request one clear-and-compact pass.
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  single-cycle pulse at pass completion.
REQ-011 rd_addr  output  AW=$clog2(ROWS)  board read address.
REQ-012 rd_data  input  COLS  board read data, valid exactly one cycle after rd_addr is presented.
REQ-013 wr_en  output  1  board write strobe.
REQ-014 wr_addr  output  AW  board write address.
REQ-015 wr_data  output  COLS  board write data.
REQ-016 lines_cleared  output  $clog2(ROWS+1)  full rows removed in the last pass; held until next pass starts.
REQ-017 score  output  24  accumulated score (see Configuration).

Function
REQ-018 States: IDLE, READ, EVAL, FILL, DONE.
REQ-019 IDLE: start=1 -> READ; src and dst loaded with BOTTOM_ROW; lines_cleared cleared to 0.
REQ-020 READ: rd_addr = src; wr_en = 0; next EVAL.
REQ-021 EVAL: row is full when rd_data equals all COLS bits set; no other pattern counts as full.
REQ-022 EVAL full: lines_cleared +1, src -1, dst unchanged, no write.
REQ-023 EVAL not full, src != dst: wr_en=1, wr_addr=dst, wr_data=rd_data; src -1, dst -1.
REQ-024 EVAL not full, src == dst: no write; src -1, dst -1.
REQ-025 EVAL with src == TOP_ROW: next FILL if the updated dst >= TOP_ROW, else DONE.
REQ-026 Otherwise EVAL -> READ.
REQ-027 FILL: wr_en=1, wr_addr=dst, wr_data=0; dst -1; after writing TOP_ROW -> DONE.
REQ-028 DONE: done=1, busy=0; next IDLE; if COLS_SCORE applies, score updated on this cycle.
REQ-029 start while busy SHALL be ignored; start in DONE SHALL be ignored.
REQ-030 src/dst pointers SHALL be AW+1 bits wide so decrement past TOP_ROW never wraps.
REQ-031 Timing: window N = BOTTOM_ROW-TOP_ROW+1; done asserted 2N+K+1 cycles after the start-sampling edge, K = lines_cleared.
REQ-032 wr_en SHALL be 0 in IDLE, READ and DONE.

Reset
REQ-033 reset SHALL force IDLE at the next edge regardless of state, aborting any pass mid-operation; no further writes issued.
REQ-034 Reset values: busy 0, done 0, wr_en 0, rd_addr 0, wr_addr 0, wr_data 0, lines_cleared 0, score 0.

Configuration
REQ-035 Macro ROW_CLEAR_SCORE_EN defined: in DONE, score += table[lines_cleared] with 0:0, 1:40, 2:100, 3:300, >=4:1200, saturating at 24'hFFFFFF.
REQ-036 Macro ROW_CLEAR_SCORE_EN undefined: score SHALL be constant 0 and no score logic synthesised; port remains.

Structure
REQ-037 Package board_pkg SHALL hold the state enum, the score table constants and the saturation limit.
REQ-038 Sub-module row_full_detect (COLS-wide AND-reduction, combinational) SHALL be instantiated once.

Verification
REQ-039 Defaults, no full rows, start pulse -> zero writes, done 41 cycles after start edge, lines_cleared 0.
REQ-040 Row 22 full, others 10'h001 -> rows 22..4 receive former rows 21..3, row 3 written 0, lines_cleared 1, done at cycle 42.
REQ-041 Rows 22,20,18,16 full, ROW_CLEAR_SCORE_EN defined -> compacted board correct, lines_cleared 4, score 1200; second identical pass -> score 2400.
REQ-042 All rows 3..22 full -> all 20 rows end 0, lines_cleared 20, score +1200 with macro, score 0 without.
REQ-043 Row value 10'h3FE (one hole) -> not cleared; start asserted during busy -> ignored, single done pulse.
REQ-044 reset asserted in FILL -> next cycle IDLE, wr_en 0, busy 0, lines_cleared 0, no further writes.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and constants for the row clear engine: FSM state encoding,
// per-pass score table and score saturation limit.
package board_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_FILL,
        ST_DONE
    } state_t;

    localparam int unsigned SCORE_W = 24;

    localparam logic [SCORE_W-1:0] SCORE_LINES_0 = 24'd0;
    localparam logic [SCORE_W-1:0] SCORE_LINES_1 = 24'd40;
    localparam logic [SCORE_W-1:0] SCORE_LINES_2 = 24'd100;
    localparam logic [SCORE_W-1:0] SCORE_LINES_3 = 24'd300;
    localparam logic [SCORE_W-1:0] SCORE_LINES_4 = 24'd1200;
    localparam logic [SCORE_W-1:0] SCORE_SAT     = 24'hFFFFFF;

    // Points awarded for one pass; four or more lines earn the top award
    function automatic logic [SCORE_W-1:0] score_for_lines(input logic [31:0] lines);
        logic [SCORE_W-1:0] pts;
        case (lines)
            32'd0:   pts = SCORE_LINES_0;
            32'd1:   pts = SCORE_LINES_1;
            32'd2:   pts = SCORE_LINES_2;
            32'd3:   pts = SCORE_LINES_3;
            default: pts = SCORE_LINES_4;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row detector: high only when every cell bit is set.
module row_full_detect #(
    parameter int unsigned COLS = 10
) (
    input  logic [COLS-1:0] i_row,
    output logic            o_full_c
);

    assign o_full_c = &i_row;

endmodule

// File: rtl/row_clear_engine.sv
// Clear-and-compact engine: walks the playfield bottom-up, drops full rows,
// shifts survivors down and zero-fills the vacated top rows.
// Optional scoring is enabled by defining ROW_CLEAR_SCORE_EN.
module row_clear_engine
    import board_pkg::*;
#(
    parameter int unsigned COLS       = 10,
    parameter int unsigned ROWS       = 32,
    parameter int unsigned TOP_ROW    = 3,
    parameter int unsigned BOTTOM_ROW = 22
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(ROWS)-1:0]    rd_addr,
    input  logic [COLS-1:0]            rd_data,
    output logic                       wr_en,
    output logic [$clog2(ROWS)-1:0]    wr_addr,
    output logic [COLS-1:0]            wr_data,
    output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
    output logic [23:0]                score
);

    localparam int unsigned AW = $clog2(ROWS);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = $clog2(ROWS + 1);

    state_t          r_state;
    logic [PW-1:0]   r_src;
    logic [PW-1:0]   r_dst;
    logic [AW-1:0]   r_rd_addr;
    logic            r_busy;
    logic            r_done;
    logic [LW-1:0]   r_lines;

    logic            w_full;
    logic [PW-1:0]   w_dst_next;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [COLS-1:0] w_wr_data;

    row_full_detect #(
        .COLS (COLS)
    ) u_row_full_detect (
        .i_row    (rd_data),
        .o_full_c (w_full)
    );

    // Write port is driven from the current state so the copy lands in the
    // same cycle the source row is evaluated.
    always_comb begin
        w_dst_next = w_full ? r_dst : r_dst - PW'(1);
        w_wr_en    = 1'b0;
        w_wr_addr  = '0;
        w_wr_data  = '0;
        case (r_state)
            ST_EVAL: begin
                if (!w_full && (r_src != r_dst)) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_dst[AW-1:0];
                    w_wr_data = rd_data;
                end
            end
            ST_FILL: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_dst[AW-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_lines   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_READ;
                        r_src     <= PW'(BOTTOM_ROW);
                        r_dst     <= PW'(BOTTOM_ROW);
                        r_rd_addr <= AW'(BOTTOM_ROW);
                        r_lines   <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_state <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (w_full) begin
                        r_lines <= r_lines + LW'(1);
                    end
                    r_src <= r_src - PW'(1);
                    r_dst <= w_dst_next;
                    if (r_src == PW'(TOP_ROW)) begin
                        r_state <= (w_dst_next >= PW'(TOP_ROW)) ? ST_FILL : ST_DONE;
                    end else begin
                        r_state   <= ST_READ;
                        r_rd_addr <= AW'(r_src - PW'(1));
                    end
                end
                ST_FILL: begin
                    r_dst <= r_dst - PW'(1);
                    if (r_dst == PW'(TOP_ROW)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ROW_CLEAR_SCORE_EN
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W:0]   w_score_sum;

    always_comb begin
        w_score_sum = {1'b0, r_score} + {1'b0, score_for_lines(32'(r_lines))};
    end

    // Accumulate once per pass, clamped at the saturation limit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_score <= '0;
        end else if (r_state == ST_DONE) begin
            r_score <= (w_score_sum > {1'b0, SCORE_SAT}) ? SCORE_SAT
                                                         : w_score_sum[SCORE_W-1:0];
        end
    end

    assign score = r_score;
`else
    assign score = '0;
`endif

    assign busy          = r_busy;
    assign done          = r_done;
    assign rd_addr       = r_rd_addr;
    assign wr_en         = w_wr_en;
    assign wr_addr       = w_wr_addr;
    assign wr_data       = w_wr_data;
    assign lines_cleared = r_lines;

endmodule
